nor4_selftest_seq: RTL and testbench
====================================

// Module: nor4_selftest_seq
// PURPOSE
//  Self-test sequencer for the 4-input NOR gate datapath (nor_gate_4_* family).
//  On start, it walks inputs a,b,c,d through all 16 combinations, with a as the MSB.
//  After a programmable settle time it samples the gate output and compares it to the expected truth table.
//  It records per-vector failures and reports pass/fail, replacing free-running clock-divided bench stimulus.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles the vector is held before the sample cycle; legal range 1..15
//  INVERT         1  1: expected = NOR(a,b,c,d); 0: expected = OR(a,b,c,d)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous active-low reset
//  start      in   1   level request to run one full sweep
//  gate_out   in   1   output of the gate under test
//  a          out  1   gate input, vec[3]
//  b          out  1   gate input, vec[2]
//  c          out  1   gate input, vec[1]
//  d          out  1   gate input, vec[0]
//  busy       out  1   high while a sweep is in progress
//  done       out  1   high in DONE; sweep results valid
//  pass       out  1   high in DONE when err_count==0
//  err_count  out  5   number of mismatching vectors, 0..16
//  fail_vec   out  16  bit i set when vector i mismatched
// BEHAVIOUR
//  Reset values
//   - rst_n low at a clk edge: state=IDLE, vec=0, cnt=0, a..d=0.
//   - busy=done=pass=0, err_count=0, fail_vec=0.
//   - Reset overrides every other input, including mid-sweep; any partial result is discarded.
//  All outputs are registered; no combinational path from inputs to outputs.
//  {a,b,c,d} always equals vec.
//  State IDLE
//   - Outputs held.
//   - start=1 at an edge -> SETTLE, with vec=0, cnt=SETTLE_CYCLES-1, err_count=0, fail_vec=0, busy=1, done=0, pass=0.
//  State SETTLE
//   - Vector is held. cnt decrements each edge.
//   - At the edge where cnt==0 -> SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
//  State SAMPLE (1 cycle)
//   - At the exiting edge, gate_out is compared to exp = INVERT ? ~|vec : |vec.
//   - On mismatch: fail_vec[vec] <= 1 and err_count <= err_count+1.
//   - If vec!=15: vec <= vec+1, cnt <= SETTLE_CYCLES-1, next state SETTLE.
//   - If vec==15: next state DONE, busy <= 0, done <= 1, pass <= (final err_count==0).
//     pass must include the vector-15 result.
//   - vec never wraps during a sweep; it stays 15 in DONE.
//  State DONE
//   - Results held.
//   - While start=1, remain in DONE; no automatic restart.
//   - start=0 at an edge -> IDLE; done <= 0 and pass <= 0 there.
//   - a..d, err_count and fail_vec keep their values in IDLE until the next start.
//  start is ignored while busy; this covers re-assertion and glitches.
//  Latency: from the edge sampling start in IDLE to done=1 is 16*(SETTLE_CYCLES+1) edges.
//   - At the default setting this is 48.
//  Settle margin: gate_out is sampled SETTLE_CYCLES+1 edges after the vector changes.
//  err_count saturation is unnecessary; 5 bits hold 16.
// TESTING
//  1. Ideal NOR model, SETTLE=2, pulse start -> a..d step 0000..1111; done=1 exactly 48 edges after start; err_count=0, fail_vec=16'h0000, pass=1.
//  2. gate_out tied 0 -> err_count=1, fail_vec=16'h0001, pass=0.
//  3. gate_out tied 1 -> err_count=15, fail_vec=16'hFFFE, pass=0.
//  4. INVERT=0 with ideal NOR model -> err_count=16, fail_vec=16'hFFFF. Then start held high 10 cycles after done -> stays in DONE. Then start low -> IDLE next edge with done=0. Also: start toggled mid-sweep has no effect on timing.
//  5. rst_n low for 1 edge while vec=7 -> next cycle all outputs 0 and state IDLE. Restart with ideal model -> pass=1 after 48 edges.
//  6. Model with 3-register output delay: SETTLE=4 -> pass=1; SETTLE=1 -> pass=0 and err_count>0.

Source files
------------

// File: rtl/nor4_selftest_seq_if.sv
// ----------------------------------------------------------------------------
// nor4_selftest_seq_if
//   Bundles the signals between the NOR4 self-test sequencer and its
//   environment (gate under test plus controlling logic).
//   Signal names carry the sequencer's point of view (_i into it, _o out).
//
//   start_i       level request to run one full sweep
//   gate_out_i    output of the gate under test
//   a_o..d_o      gate inputs, a_o is the MSB of the current vector
//   busy_o        sweep in progress
//   done_o        sweep finished, results valid
//   pass_o        sweep finished with zero mismatches
//   err_count_o   number of mismatching vectors (0..16)
//   fail_vec_o    bit i set when vector i mismatched
//
//   master : the sequencer
//   slave  : the environment driving start/gate_out
// ----------------------------------------------------------------------------
interface nor4_selftest_seq_if;
  logic        start_i;
  logic        gate_out_i;
  logic        a_o;
  logic        b_o;
  logic        c_o;
  logic        d_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [4:0]  err_count_o;
  logic [15:0] fail_vec_o;

  modport master (
    input  start_i, gate_out_i,
    output a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_count_o, fail_vec_o
  );

  modport slave (
    output start_i, gate_out_i,
    input  a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_count_o, fail_vec_o
  );
endinterface

// File: rtl/nor4_selftest_seq.sv
// ----------------------------------------------------------------------------
// nor4_selftest_seq
//   Self-test sequencer for a 4-input NOR gate. On start it walks {a,b,c,d}
//   through vectors 0..15, holds each vector for SETTLE_CYCLES cycles, then
//   samples gate_out for one cycle and compares it against the expected truth
//   table. Mismatches are logged per vector; a pass flag is raised in DONE.
//
//   Parameters
//     SETTLE_CYCLES  hold cycles before the sample cycle (legal 1..15)
//     INVERT         1: expect NOR(a,b,c,d), 0: expect OR(a,b,c,d)
//
//   Ports
//     clk_i    rising-edge clock
//     rst_n_i  synchronous active-low reset
//     bus      nor4_selftest_seq_if.master (start, gate_out, a..d, status)
//
//   All outputs come straight from registers.
// ----------------------------------------------------------------------------
module nor4_selftest_seq #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          INVERT        = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  nor4_selftest_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q,   vec_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        pass_q,  pass_d;
  logic [4:0]  err_q,   err_d;
  logic [15:0] fv_q,    fv_d;

  logic        exp_bit;
  logic        mismatch;
  logic [4:0]  err_inc;
  logic [15:0] fv_upd;

  assign exp_bit  = INVERT ? ~|vec_q : |vec_q;
  assign mismatch = (bus.gate_out_i != exp_bit);
  // Result of the current sample folded in; only committed in SAMPLE.
  assign err_inc  = err_q + 5'(mismatch);
  assign fv_upd   = fv_q | (16'(mismatch) << vec_q);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = SETTLE;
          vec_d   = 4'd0;
          cnt_d   = CNT_INIT;
          err_d   = 5'd0;
          fv_d    = 16'h0000;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        err_d = err_inc;
        fv_d  = fv_upd;
        if (vec_q != 4'd15) begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else begin
          // vec stays at 15; pass uses the count including vector 15.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == 5'd0);
        end
      end
      DONE: begin
        // No auto-restart: start must drop before another sweep can begin.
        if (!bus.start_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      fv_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.a_o         = vec_q[3];
  assign bus.b_o         = vec_q[2];
  assign bus.c_o         = vec_q[1];
  assign bus.d_o         = vec_q[0];
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.err_count_o = err_q;
  assign bus.fail_vec_o  = fv_q;

endmodule

// File: tb/tb_nor4_selftest_seq.sv
// ----------------------------------------------------------------------------
// tb_nor4_selftest_seq
//   Four sequencer instances with different parameters and gate models:
//     0: SETTLE=2 INVERT=1, gate model selectable (ideal NOR / stuck 0 / stuck 1)
//     1: SETTLE=2 INVERT=0, ideal NOR gate
//     2: SETTLE=4 INVERT=1, NOR gate with 3-register output delay
//     3: SETTLE=1 INVERT=1, NOR gate with 3-register output delay
//   Expected sweep results are pushed to a scoreboard queue when a sweep is
//   launched and popped when done rises.
// ----------------------------------------------------------------------------
module tb_nor4_selftest_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;   // instance 0 gate: 0 ideal, 1 stuck-0, 2 stuck-1

  logic        start_r [4];
  logic [3:0]  vec_w   [4];
  logic        busy_w  [4];
  logic        done_w  [4];
  logic        pass_w  [4];
  logic [4:0]  err_w   [4];
  logic [15:0] fv_w    [4];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  err;
    logic [15:0] fv;
    logic        pass;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    nor4_selftest_seq_if bus_if ();
    logic nor_v;

    assign nor_v          = ~|{bus_if.a_o, bus_if.b_o, bus_if.c_o, bus_if.d_o};
    assign bus_if.start_i = start_r[gi];
    assign vec_w[gi]      = {bus_if.a_o, bus_if.b_o, bus_if.c_o, bus_if.d_o};
    assign busy_w[gi]     = bus_if.busy_o;
    assign done_w[gi]     = bus_if.done_o;
    assign pass_w[gi]     = bus_if.pass_o;
    assign err_w[gi]      = bus_if.err_count_o;
    assign fv_w[gi]       = bus_if.fail_vec_o;

    if (gi == 0) begin : g_sel
      assign bus_if.gate_out_i = (mode == 2'd0) ? nor_v :
                                 (mode == 2'd1) ? 1'b0 : 1'b1;
    end else if (gi == 1) begin : g_ideal
      assign bus_if.gate_out_i = nor_v;
    end else begin : g_delay
      logic g_q1, g_q2, g_q3;
      always_ff @(posedge clk) begin
        g_q1 <= nor_v;
        g_q2 <= g_q1;
        g_q3 <= g_q2;
      end
      assign bus_if.gate_out_i = g_q3;
    end

    nor4_selftest_seq #(
      .SETTLE_CYCLES((gi == 2) ? 4 : (gi == 3) ? 1 : 2),
      .INVERT       ((gi == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus_if.master)
    );
  end

  // Launch one sweep on instance idx and wait for done; lat = edges from the
  // start-sampling edge to done=1, or -1 on timeout.
  task automatic do_sweep(input int idx, input bit toggle, output int lat);
    start_r[idx] = 1'b0;
    @(posedge clk); #1;
    start_r[idx] = 1'b1;
    @(posedge clk); #1;
    start_r[idx] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (toggle) start_r[idx] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done_w[idx]) begin
        lat = k;
        break;
      end
    end
    if (toggle) start_r[idx] = 1'b0;
    $display("sweep inst=%0d latency=%0d err_count=%0d fail_vec=%h pass=%0b",
             idx, lat, err_w[idx], fv_w[idx], pass_w[idx]);
  endtask

  task automatic push_exp(input logic [4:0] err, input logic [15:0] fv, input logic pass);
    exp_t e;
    e.err  = err;
    e.fv   = fv;
    e.pass = pass;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({vec_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i]} !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_outputs inst=%0d: got vec=%h busy=%b done=%b pass=%b err=%0d fv=%h, expected all zero",
                 i, vec_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], fv_w[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy_w[0] !== 1'b0 || vec_w[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b vec=%h, expected busy=0 vec=0", busy_w[0], vec_w[0]);
    end
  endtask

  task automatic test_ideal_sweep();
    exp_t e;
    logic [3:0] exp_vec;
    mode = 2'd0;
    push_exp(5'd0, 16'h0000, 1'b1);
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      exp_vec = (k >= 45) ? 4'd15 : 4'(k / 3);
      n_checks++;
      if (vec_w[0] !== exp_vec) begin
        n_fail++;
        $display("FAIL ideal_vec_step k=%0d: got %h expected %h", k, vec_w[0], exp_vec);
      end
      if (k == 1) begin
        n_checks++;
        if (busy_w[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL ideal_busy: got %b expected 1", busy_w[0]);
        end
      end
      if (k == 47) begin
        n_checks++;
        if (done_w[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL ideal_done_early: got done=%b at edge 47, expected 0", done_w[0]);
        end
      end
    end
    n_checks++;
    if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ideal_done_at_48: got done=%b busy=%b expected done=1 busy=0", done_w[0], busy_w[0]);
    end
    $display("sweep inst=0 latency=48 err_count=%0d fail_vec=%h pass=%0b", err_w[0], fv_w[0], pass_w[0]);
    e = sb_q.pop_front();
    n_checks++;
    if ({err_w[0], fv_w[0], pass_w[0]} !== e) begin
      n_fail++;
      $display("FAIL ideal_result: got err=%0d fv=%h pass=%b expected err=%0d fv=%h pass=%b",
               err_w[0], fv_w[0], pass_w[0], e.err, e.fv, e.pass);
    end
  endtask

  task automatic test_stuck_gate(input logic [1:0] m, input logic [4:0] x_err, input logic [15:0] x_fv);
    exp_t e;
    int lat;
    mode = m;
    push_exp(x_err, x_fv, 1'b0);
    do_sweep(0, 1'b0, lat);
    n_checks++;
    if (lat != 48) begin
      n_fail++;
      $display("FAIL stuck%0d_latency: got %0d expected 48", m, lat);
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({err_w[0], fv_w[0], pass_w[0]} !== e) begin
      n_fail++;
      $display("FAIL stuck%0d_result: got err=%0d fv=%h pass=%b expected err=%0d fv=%h pass=%b",
               m, err_w[0], fv_w[0], pass_w[0], e.err, e.fv, e.pass);
    end
    mode = 2'd0;
  endtask

  task automatic test_invert0_hold();
    exp_t e;
    int lat;
    push_exp(5'd16, 16'hFFFF, 1'b0);
    do_sweep(1, 1'b1, lat);   // start toggled randomly while busy
    n_checks++;
    if (lat != 48) begin
      n_fail++;
      $display("FAIL inv0_latency_with_toggle: got %0d expected 48", lat);
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({err_w[1], fv_w[1], pass_w[1]} !== e) begin
      n_fail++;
      $display("FAIL inv0_result: got err=%0d fv=%h pass=%b expected err=%0d fv=%h pass=%b",
               err_w[1], fv_w[1], pass_w[1], e.err, e.fv, e.pass);
    end
    start_r[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL inv0_hold_done k=%0d: got done=%b busy=%b expected done=1 busy=0", k, done_w[1], busy_w[1]);
      end
    end
    start_r[1] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done_w[1], pass_w[1], busy_w[1]} !== 3'b000) begin
      n_fail++;
      $display("FAIL inv0_to_idle: got done=%b pass=%b busy=%b expected 0 0 0", done_w[1], pass_w[1], busy_w[1]);
    end
    n_checks++;
    if (err_w[1] !== 5'd16 || fv_w[1] !== 16'hFFFF || vec_w[1] !== 4'd15) begin
      n_fail++;
      $display("FAIL inv0_idle_keeps_results: got err=%0d fv=%h vec=%h expected 16 ffff f", err_w[1], fv_w[1], vec_w[1]);
    end
  endtask

  task automatic test_reset_midsweep();
    exp_t e;
    int lat;
    bit seen;
    mode = 2'd0;
    start_r[0] = 1'b0;
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (vec_w[0] == 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midsweep_reach_vec7: got vec=%h expected 7 within 100 cycles", vec_w[0]);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if ({vec_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fv_w[0]} !== 28'h0) begin
      n_fail++;
      $display("FAIL midsweep_reset_outputs: got vec=%h busy=%b done=%b pass=%b err=%0d fv=%h expected all zero",
               vec_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fv_w[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy_w[0] !== 1'b0 || vec_w[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midsweep_idle: got busy=%b vec=%h expected busy=0 vec=0", busy_w[0], vec_w[0]);
    end
    push_exp(5'd0, 16'h0000, 1'b1);
    do_sweep(0, 1'b0, lat);
    n_checks++;
    if (lat != 48) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected 48", lat);
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({err_w[0], fv_w[0], pass_w[0]} !== e) begin
      n_fail++;
      $display("FAIL restart_result: got err=%0d fv=%h pass=%b expected err=%0d fv=%h pass=%b",
               err_w[0], fv_w[0], pass_w[0], e.err, e.fv, e.pass);
    end
  endtask

  task automatic test_delay_model();
    exp_t e;
    int lat;
    push_exp(5'd0, 16'h0000, 1'b1);
    do_sweep(2, 1'b0, lat);
    n_checks++;
    if (lat != 80) begin
      n_fail++;
      $display("FAIL settle4_latency: got %0d expected 80", lat);
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({err_w[2], fv_w[2], pass_w[2]} !== e) begin
      n_fail++;
      $display("FAIL settle4_result: got err=%0d fv=%h pass=%b expected err=%0d fv=%h pass=%b",
               err_w[2], fv_w[2], pass_w[2], e.err, e.fv, e.pass);
    end
    do_sweep(3, 1'b0, lat);
    n_checks++;
    if (lat != 32) begin
      n_fail++;
      $display("FAIL settle1_latency: got %0d expected 32", lat);
    end
    n_checks++;
    if (pass_w[3] !== 1'b0 || err_w[3] === 5'd0 || done_w[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL settle1_result: got pass=%b err=%0d done=%b expected pass=0 err>0 done=1",
               pass_w[3], err_w[3], done_w[3]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) start_r[i] = 1'b0;
    test_reset();
    test_ideal_sweep();
    test_stuck_gate(2'd1, 5'd1, 16'h0001);
    test_stuck_gate(2'd2, 5'd15, 16'hFFFE);
    test_invert0_hold();
    test_reset_midsweep();
    test_delay_model();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
